pipe_arbiter: RTL and testbench

PIPE_ARBITER -- requirements
Module: pipe_arbiter

---
 rtl/pipe_arbiter.sv | 127 ++++++++++++
 tb/tb_pipe_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_arbiter.sv
// pipe_arbiter: round-robin arbiter feeding one shared fixed-latency pipeline, returning results by tag.
// Build macro PIPE_ARB_PRIO_EN gives requester 0 strict priority over a round-robin among the rest.
module pipe_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 32,
    parameter int LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*WIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]         req_ready,
    input  logic                     flush,
    output logic [WIDTH-1:0]         pipe_din,
    output logic                     pipe_rst,
    input  logic [WIDTH-1:0]         pipe_dout,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     busy
);

    localparam int IDW = $clog2(N_REQ);
`ifdef PIPE_ARB_PRIO_EN
    localparam int N_RR = N_REQ - 1;
`else
    localparam int N_RR = N_REQ;
`endif

    logic [IDW-1:0]              r_ptr;
    logic [LATENCY-1:0]          r_tag_vld;
    logic [LATENCY-1:0][IDW-1:0] r_tag_id;

    logic           w_found;
    logic           w_xfer;
    logic           w_ptr_upd;
    logic           w_rsp_hit;
    logic [IDW-1:0] w_gnt_id;
    logic [IDW-1:0] w_rsp_id;

    // k-th candidate after the pointer; with priority enabled the ring excludes requester 0
    function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] ptr, input int k);
        int v;
`ifdef PIPE_ARB_PRIO_EN
        v = ((int'(ptr) + N_RR - 1 + k) % N_RR) + 1;
`else
        v = (int'(ptr) + k) % N_RR;
`endif
        return v[IDW-1:0];
    endfunction

    always_comb begin
        w_found  = 1'b0;
        w_gnt_id = '0;
`ifdef PIPE_ARB_PRIO_EN
        if (req_valid[0]) begin
            w_found = 1'b1;
        end else begin
            for (int k = 1; k <= N_RR; k++) begin
                if (!w_found && req_valid[rr_idx(r_ptr, k)]) begin
                    w_found  = 1'b1;
                    w_gnt_id = rr_idx(r_ptr, k);
                end
            end
        end
        w_xfer    = w_found & ~flush & rst_n;
        w_ptr_upd = w_xfer & (w_gnt_id != '0);
`else
        for (int k = 1; k <= N_RR; k++) begin
            if (!w_found && req_valid[rr_idx(r_ptr, k)]) begin
                w_found  = 1'b1;
                w_gnt_id = rr_idx(r_ptr, k);
            end
        end
        w_xfer    = w_found & ~flush & rst_n;
        w_ptr_upd = w_xfer;
`endif
    end

    always_comb begin
        req_ready = '0;
        pipe_din  = '0;
        if (w_xfer) begin
            req_ready[w_gnt_id] = 1'b1;
            pipe_din            = req_data[int'(w_gnt_id)*WIDTH +: WIDTH];
        end
    end

    // Response side: the oldest tag lines up with the pipeline output
    always_comb begin
        w_rsp_id  = r_tag_id[LATENCY-1];
        w_rsp_hit = r_tag_vld[LATENCY-1] & ~flush;
        rsp_valid = '0;
        rsp_data  = '0;
        if (w_rsp_hit) begin
            rsp_valid[w_rsp_id] = 1'b1;
            rsp_data            = pipe_dout;
        end
    end

    assign pipe_rst = flush | ~rst_n;
    assign busy     = |r_tag_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr     <= IDW'(N_REQ - 1);
            r_tag_vld <= '0;
            r_tag_id  <= '0;
        end else begin
            if (w_ptr_upd) begin
                r_ptr <= w_gnt_id;
            end
            if (flush) begin
                r_tag_vld <= '0;
            end else begin
                r_tag_vld[0] <= w_xfer;
                for (int i = 1; i < LATENCY; i++) begin
                    r_tag_vld[i] <= r_tag_vld[i-1];
                end
            end
            r_tag_id[0] <= w_gnt_id;
            for (int i = 1; i < LATENCY; i++) begin
                r_tag_id[i] <= r_tag_id[i-1];
            end
        end
    end

endmodule

// File: tb/tb_pipe_arbiter.sv
// Directed bench for pipe_arbiter (N_REQ=4, WIDTH=32, LATENCY=3) with a 3-stage pipeline model.
// Priority expectations follow PIPE_ARB_PRIO_EN when the bench is built with it.
module tb_pipe_arbiter;

    localparam int N = 4;
    localparam int W = 32;
    localparam int L = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   req_ready;
    logic           flush;
    logic [W-1:0]   pipe_din;
    logic           pipe_rst;
    logic [W-1:0]   pipe_dout;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_data;
    logic           busy;

    logic [W-1:0] dat [N];
    logic [W-1:0] s_pipe [L];

    int nvec = 0;
    int nerr = 0;

    pipe_arbiter #(.N_REQ(N), .WIDTH(W), .LATENCY(L)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .flush     (flush),
        .pipe_din  (pipe_din),
        .pipe_rst  (pipe_rst),
        .pipe_dout (pipe_dout),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    assign req_data  = {dat[3], dat[2], dat[1], dat[0]};
    assign pipe_dout = s_pipe[L-1];

    // Attached pipeline: STAGES=3 register chain with synchronous active-high reset
    always @(posedge clk) begin
        if (pipe_rst) begin
            for (int i = 0; i < L; i++) s_pipe[i] <= '0;
        end else begin
            s_pipe[0] <= pipe_din;
            for (int i = 1; i < L; i++) s_pipe[i] <= s_pipe[i-1];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_rsp(input string tag);
        chk({tag, "_rspv"}, 64'(rsp_valid), 64'h0);
        chk({tag, "_rspd"}, 64'(rsp_data), 64'h0);
    endtask

    initial begin
        dat[0] = 32'hA5A5_0001;
        dat[1] = 32'hB0B0_0011;
        dat[2] = 32'hC0C0_0022;
        dat[3] = 32'hD0D0_0033;
        rst_n = 1'b0;
        flush = 1'b0;
        req_valid = 4'b1111;

        // Reset state, with every requester asking
        tick;
        #1;
        chk("rst_ready", 64'(req_ready), 64'h0);
        chk("rst_din", 64'(pipe_din), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_piperst", 64'(pipe_rst), 64'h1);
        chk_idle_rsp("rst");
        tick;
        rst_n = 1'b1;
        req_valid = 4'b0000;
        tick;

        // Single request, response 3 cycles later
        req_valid = 4'b0001;
        #1;
        chk("s_ready", 64'(req_ready), 64'h1);
        chk("s_din", 64'(pipe_din), 64'hA5A5_0001);
        chk("s_busy0", 64'(busy), 64'h0);
        chk("s_piperst", 64'(pipe_rst), 64'h0);
        tick;
        req_valid = 4'b0000;
        #1;
        chk("s_busy1", 64'(busy), 64'h1);
        chk("s_din_idle", 64'(pipe_din), 64'h0);
        chk_idle_rsp("s1");
        tick;
        #1;
        chk("s_busy2", 64'(busy), 64'h1);
        chk_idle_rsp("s2");
        tick;
        #1;
        chk("s_rspv", 64'(rsp_valid), 64'h1);
        chk("s_rspd", 64'(rsp_data), 64'hA5A5_0001);
        chk("s_busy3", 64'(busy), 64'h1);
        tick;
        #1;
        chk("s_busy4", 64'(busy), 64'h0);
        chk_idle_rsp("s4");

        // Contention from reset: grants 0,1,2,3,0,... and responses in order 3 later
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        for (int k = 0; k < 11; k++) begin
            req_valid = (k < 8) ? 4'b1111 : 4'b0000;
            #1;
            chk("c_ready", 64'(req_ready), (k < 8) ? (64'h1 << (k % 4)) : 64'h0);
            if (k >= 3) begin
                chk("c_rspv", 64'(rsp_valid), 64'h1 << ((k - 3) % 4));
                chk("c_rspd", 64'(rsp_data), 64'(dat[(k - 3) % 4]));
            end else begin
                chk_idle_rsp("c_pre");
            end
            tick;
        end
        req_valid = 4'b0000;
        #1;
        chk("c_busy_end", 64'(busy), 64'h0);
        tick;

        // Flush: req1, req2, then flush drops both; pointer kept (last grant 2 -> 3 next)
        req_valid = 4'b0010;
        #1;
        chk("f_ready1", 64'(req_ready), 64'h2);
        tick;
        req_valid = 4'b0100;
        #1;
        chk("f_ready2", 64'(req_ready), 64'h4);
        tick;
        req_valid = 4'b0001;
        flush = 1'b1;
        #1;
        chk("f_ready_fl", 64'(req_ready), 64'h0);
        chk("f_piperst", 64'(pipe_rst), 64'h1);
        chk("f_din", 64'(pipe_din), 64'h0);
        chk_idle_rsp("f22");
        tick;
        flush = 1'b0;
        req_valid = 4'b1111;
        #1;
        chk("f_busy23", 64'(busy), 64'h0);
        chk("f_ready_post", 64'(req_ready), 64'h8);
        chk_idle_rsp("f23");
        tick;
        req_valid = 4'b0000;
        #1;
        chk_idle_rsp("f24");
        tick;
        #1;
        chk_idle_rsp("f25");
        tick;
        #1;
        chk("f_rspv_post", 64'(rsp_valid), 64'h8);
        chk("f_rspd_post", 64'(rsp_data), 64'hD0D0_0033);
        tick;

        // Reset mid-flight: nothing may come back after release
        req_valid = 4'b0001;
        #1;
        chk("r_ready", 64'(req_ready), 64'h1);
        tick;
        rst_n = 1'b0;
        req_valid = 4'b1111;
        #1;
        chk("r_ready_rst", 64'(req_ready), 64'h0);
        chk("r_din_rst", 64'(pipe_din), 64'h0);
        chk("r_busy_rst", 64'(busy), 64'h0);
        chk("r_piperst", 64'(pipe_rst), 64'h1);
        chk_idle_rsp("r31");
        tick;
        #1;
        chk("r_piperst2", 64'(pipe_rst), 64'h1);
        chk_idle_rsp("r32");
        tick;
        rst_n = 1'b1;
        req_valid = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("r_busy_post", 64'(busy), 64'h0);
            chk_idle_rsp("r_post");
            tick;
        end

        // req0 and req2 both valid from a fresh reset
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req_valid = 4'b0101;
            #1;
`ifdef PIPE_ARB_PRIO_EN
            chk("p_ready", 64'(req_ready), 64'h1);
`else
            chk("p_ready", 64'(req_ready), (k % 2 == 0) ? 64'h1 : 64'h4);
`endif
            tick;
        end
        req_valid = 4'b0100;
        #1;
        chk("p_ready_r2", 64'(req_ready), 64'h4);
        chk("p_din_r2", 64'(pipe_din), 64'hC0C0_0022);
        tick;
        req_valid = 4'b0000;
        for (int k = 0; k < 4; k++) tick;
        #1;
        chk("p_busy_end", 64'(busy), 64'h0);
        chk_idle_rsp("p_end");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
